// File: rtl/conv_io_sequencer_if.sv
// System-side streams of the conv I/O sequencer: job config, IFMap and
// filter sources, psum sink.
interface conv_io_sequencer_if #(
  parameter int IFMAP_WIDTH          = 18,
  parameter int FILTER_WIDTH         = 8,
  parameter int STRIDE_SIZE          = 3,
  parameter int FILTER_SIZE_REG_SIZE = 8
);
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [STRIDE_SIZE-1:0]          cfg_stride;
  logic [FILTER_SIZE_REG_SIZE-1:0] cfg_filter_size;
  logic [FILTER_SIZE_REG_SIZE-1:0] cfg_row_len;
  logic                            cfg_err;

  logic                            if_valid;
  logic                            if_ready;
  logic [IFMAP_WIDTH-1:0]          if_data;

  logic                            flt_valid;
  logic                            flt_ready;
  logic [FILTER_WIDTH-1:0]         flt_data;

  logic                            ps_valid;
  logic                            ps_ready;
  logic [IFMAP_WIDTH-1:0]          ps_data;

  modport master (
    output cfg_valid, cfg_stride, cfg_filter_size, cfg_row_len,
    input  cfg_ready, cfg_err,
    output if_valid, if_data,
    input  if_ready,
    output flt_valid, flt_data,
    input  flt_ready,
    input  ps_valid, ps_data,
    output ps_ready
  );

  modport slave (
    input  cfg_valid, cfg_stride, cfg_filter_size, cfg_row_len,
    output cfg_ready, cfg_err,
    input  if_valid, if_data,
    output if_ready,
    input  flt_valid, flt_data,
    output flt_ready,
    output ps_valid, ps_data,
    input  ps_ready
  );
endinterface

// File: rtl/conv_io_sequencer.sv
// Front-end sequencer for the 1-D convolution PE core: validates a job,
// counts output windows, loads filter and IFMap buffers, starts the core
// and drains the resulting psums onto the sink stream.
module conv_io_sequencer #(
  parameter int IFMAP_WIDTH          = 18,
  parameter int FILTER_WIDTH         = 8,
  parameter int STRIDE_SIZE          = 3,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int IFMAP_BUFFER_DEPTH   = 16,
  parameter int FILTER_BUFFER_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  conv_io_sequencer_if.slave              bus,
  output logic                            start,
  output logic                            chip_en,
  output logic                            wen_IFMap_buffer,
  output logic                            wen_Filter_buffer,
  output logic                            ren_Psum_buffer,
  output logic [STRIDE_SIZE-1:0]          stride,
  output logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
  output logic [IFMAP_WIDTH-1:0]          IFMap_in,
  output logic [FILTER_WIDTH-1:0]         Filter_in,
  input  logic [IFMAP_WIDTH-1:0]          Psum_out,
  input  logic                            done,
  output logic                            busy,
  output logic                            job_done
);

  // One extra bit so pos + filter_size can never wrap.
  localparam int CW = FILTER_SIZE_REG_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, LOAD_FLT, LOAD_IF, START, RUN, DRAIN, FINISH
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     row_len_q;
  logic [CW-1:0]     n_out;
  logic [CW-1:0]     pos;
  logic [CW-1:0]     load_cnt;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     rd_cnt;
  logic              rd_pend;
  logic              ps_valid_q;
  logic [IFMAP_WIDTH-1:0] ps_data_q;
  logic              cfg_err_q;

  logic              cfg_fire, cfg_bad, fits;
  logic              flt_fire, if_fire, ps_fire;
  logic              last_flt, last_if;
  logic [CW-1:0]     fs_ext, cfg_fs_ext, cfg_rl_ext;

  assign fs_ext     = {1'b0, filter_size};
  assign cfg_fs_ext = {1'b0, bus.cfg_filter_size};
  assign cfg_rl_ext = {1'b0, bus.cfg_row_len};

  assign cfg_fire = (state == IDLE) && bus.cfg_valid;
  assign flt_fire = (state == LOAD_FLT) && bus.flt_valid;
  assign if_fire  = (state == LOAD_IF) && bus.if_valid;
  assign ps_fire  = ps_valid_q && bus.ps_ready;
  assign last_flt = (load_cnt == fs_ext - CW'(1));
  assign last_if  = (load_cnt == row_len_q - CW'(1));
  assign fits     = (pos + fs_ext) <= row_len_q;

  assign bus.ps_valid = ps_valid_q;
  assign bus.ps_data  = ps_data_q;
  assign bus.cfg_err  = cfg_err_q;

  // Config legality check, evaluated on the raw config fields.
  always_comb begin
    cfg_bad = (bus.cfg_stride == '0)
           || (bus.cfg_filter_size == '0)
           || (cfg_fs_ext > CW'(FILTER_BUFFER_DEPTH))
           || (cfg_rl_ext > CW'(IFMAP_BUFFER_DEPTH))
           || (cfg_rl_ext < cfg_fs_ext);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and core/stream strobes.
  always_comb begin
    state_nx          = state;
    bus.cfg_ready     = 1'b0;
    bus.flt_ready     = 1'b0;
    bus.if_ready      = 1'b0;
    wen_Filter_buffer = 1'b0;
    wen_IFMap_buffer  = 1'b0;
    Filter_in         = '0;
    IFMap_in          = '0;
    start             = 1'b0;
    ren_Psum_buffer   = 1'b0;
    job_done          = 1'b0;
    busy              = (state != IDLE);
    chip_en           = (state != IDLE);
    case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        if (cfg_fire && !cfg_bad) state_nx = COUNT;
      end
      COUNT: begin
        if (!fits) state_nx = LOAD_FLT;
      end
      LOAD_FLT: begin
        bus.flt_ready     = 1'b1;
        wen_Filter_buffer = bus.flt_valid;
        Filter_in         = bus.flt_data;
        if (flt_fire && last_flt) state_nx = LOAD_IF;
      end
      LOAD_IF: begin
        bus.if_ready     = 1'b1;
        wen_IFMap_buffer = bus.if_valid;
        IFMap_in         = bus.if_data;
        if (if_fire && last_if) state_nx = START;
      end
      START: begin
        start    = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        if (done) state_nx = DRAIN;
      end
      DRAIN: begin
        ren_Psum_buffer = !ps_valid_q && !rd_pend && (rd_cnt < n_out);
        // Leave on the final handshake itself so job_done lands one cycle later.
        if (ps_fire && (out_cnt + CW'(1) == n_out)) state_nx = FINISH;
      end
      FINISH: begin
        job_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job registers, window counter, load counter and psum drain datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride      <= '0;
      filter_size <= '0;
      row_len_q   <= '0;
      n_out       <= '0;
      pos         <= '0;
      load_cnt    <= '0;
      out_cnt     <= '0;
      rd_cnt      <= '0;
      rd_pend     <= 1'b0;
      ps_valid_q  <= 1'b0;
      ps_data_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_fire && cfg_bad;
      case (state)
        IDLE: begin
          if (cfg_fire && !cfg_bad) begin
            stride      <= bus.cfg_stride;
            filter_size <= bus.cfg_filter_size;
            row_len_q   <= cfg_rl_ext;
            n_out       <= '0;
            pos         <= '0;
            load_cnt    <= '0;
          end
        end
        COUNT: begin
          if (fits) begin
            n_out <= n_out + CW'(1);
            pos   <= pos + CW'(stride);
          end
        end
        LOAD_FLT: begin
          if (flt_fire) load_cnt <= last_flt ? '0 : load_cnt + CW'(1);
        end
        LOAD_IF: begin
          if (if_fire) load_cnt <= last_if ? '0 : load_cnt + CW'(1);
        end
        START: begin
          out_cnt <= '0;
          rd_cnt  <= '0;
          rd_pend <= 1'b0;
        end
        DRAIN: begin
          if (ren_Psum_buffer) begin
            rd_pend <= 1'b1;
            rd_cnt  <= rd_cnt + CW'(1);
          end
          if (rd_pend) begin
            rd_pend    <= 1'b0;
            ps_valid_q <= 1'b1;
            ps_data_q  <= Psum_out;
          end
          if (ps_fire) begin
            ps_valid_q <= 1'b0;
            out_cnt    <= out_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_io_sequencer.sv
// Directed bench for conv_io_sequencer with a tiny core model whose psum
// buffer returns 0x100 + 3*(read index + 1).
module tb_conv_io_sequencer;
  localparam int IW = 18;
  localparam int FW = 8;
  localparam int SW = 3;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_io_sequencer_if #(.IFMAP_WIDTH(IW), .FILTER_WIDTH(FW), .STRIDE_SIZE(SW),
                         .FILTER_SIZE_REG_SIZE(RW)) bus ();

  logic          start, chip_en, wen_if, wen_flt, ren, busy, job_done, done;
  logic [SW-1:0] stride_o;
  logic [RW-1:0] fs_o;
  logic [IW-1:0] IFMap_in, Psum_out;
  logic [FW-1:0] Filter_in;

  conv_io_sequencer #(
    .IFMAP_WIDTH(IW), .FILTER_WIDTH(FW), .STRIDE_SIZE(SW),
    .FILTER_SIZE_REG_SIZE(RW), .IFMAP_BUFFER_DEPTH(16), .FILTER_BUFFER_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .start(start), .chip_en(chip_en), .wen_IFMap_buffer(wen_if),
    .wen_Filter_buffer(wen_flt), .ren_Psum_buffer(ren),
    .stride(stride_o), .filter_size(fs_o), .IFMap_in(IFMap_in),
    .Filter_in(Filter_in), .Psum_out(Psum_out), .done(done),
    .busy(busy), .job_done(job_done)
  );

  // Strobe counters and core psum-buffer model.
  int c_wf = 0, c_wi = 0, c_st = 0, c_ren = 0, c_jd = 0, rd_issued = 0;
  always @(posedge clk) begin
    if (wen_flt)  c_wf  <= c_wf + 1;
    if (wen_if)   c_wi  <= c_wi + 1;
    if (start)    c_st  <= c_st + 1;
    if (ren)      c_ren <= c_ren + 1;
    if (job_done) c_jd  <= c_jd + 1;
    if (rst || done) rd_issued <= 0;
    else if (ren)    rd_issued <= rd_issued + 1;
  end
  assign Psum_out = IW'(32'h100 + 3 * rd_issued);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int s, fs, rl, err, n, bp, stray, abort_at;
  } vec_t;

  task automatic reject_cfg(input vec_t v);
    int wf0, wi0, st0, rn0;
    wf0 = c_wf; wi0 = c_wi; st0 = c_st; rn0 = c_ren;
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_stride = SW'(v.s);
    bus.cfg_filter_size = RW'(v.fs); bus.cfg_row_len = RW'(v.rl);
    #1 chk("rej_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1 chk("rej_cfg_err", bus.cfg_err, 1);
    chk("rej_busy", busy, 0);
    @(negedge clk);
    #1 chk("rej_err_pulse_end", bus.cfg_err, 0);
    chk("rej_busy2", busy, 0);
    chk("rej_strobes", (c_wf - wf0) + (c_wi - wi0) + (c_st - st0) + (c_ren - rn0), 0);
  endtask

  task automatic run_job(input vec_t v);
    int wf0, wi0, st0, rn0, jd0, cyc, k, t;
    logic [IW-1:0] held;
    wf0 = c_wf; wi0 = c_wi; st0 = c_st; rn0 = c_ren; jd0 = c_jd;
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_stride = SW'(v.s);
    bus.cfg_filter_size = RW'(v.fs); bus.cfg_row_len = RW'(v.rl);
    #1 chk("cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1 chk("cfg_err_ok", bus.cfg_err, 0);
    chk("busy_after_cfg", busy, 1);
    chk("chip_en", chip_en, 1);
    chk("stride_out", stride_o, v.s);
    chk("fs_out", fs_o, v.fs);
    // COUNT spans n_out+1 cycles; LOAD_FLT is the (n_out+2)th cycle after acceptance.
    cyc = 1;
    while (!bus.flt_ready && cyc < 100) begin
      @(negedge clk); #1 cyc++;
    end
    chk("count_cycles", cyc, v.n + 2);
    for (int i = 0; i < v.fs; i++) begin
      bus.flt_valid = 1'b1; bus.flt_data = FW'(8'h10 + i);
      #1 if (i == 0 || i == v.fs - 1) begin
        chk("wen_flt", wen_flt, 1);
        chk("filter_in", Filter_in, 8'h10 + i);
      end
      @(negedge clk);
    end
    bus.flt_valid = 1'b0;
    #1 chk("flt_ready_off", bus.flt_ready, 0);
    chk("if_ready_on", bus.if_ready, 1);
    k = 0; t = 0;
    while (k < v.rl && t < 100) begin
      bus.if_valid = (v.bp != 0) ? ((t % 2) == 0) : 1'b1;
      bus.if_data  = IW'(18'h2000 + k);
      done = (v.stray != 0) && (t == 1);
      #1 if (bus.if_valid) begin
        if (k == 0 || k == v.rl - 1) chk("ifmap_in", IFMap_in, 18'h2000 + k);
        k++;
      end else begin
        chk("wen_if_idle", wen_if, 0);
      end
      @(negedge clk); t++;
    end
    bus.if_valid = 1'b0; done = 1'b0;
    #1 chk("start_pulse", start, 1);
    chk("if_ready_off", bus.if_ready, 0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("run_wait", {busy, start, ren}, 3'b100);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    #1 chk("first_ren", ren, 1);
    for (int j = 0; j < v.n; j++) begin
      cyc = 0;
      while (!bus.ps_valid && cyc < 20) begin
        @(negedge clk); #1 cyc++;
      end
      chk("ps_valid_wait", bus.ps_valid, 1);
      held = bus.ps_data;
      chk("ps_data", bus.ps_data, 32'h100 + 3 * (j + 1));
      if (v.bp != 0) begin
        repeat (5) begin
          @(negedge clk);
          #1 chk("stall_stable", {bus.ps_valid, ren, bus.ps_data}, {1'b1, 1'b0, held});
        end
      end
      bus.ps_ready = 1'b1;
      @(negedge clk);
      bus.ps_ready = 1'b0;
      if (v.abort_at != 0 && j + 1 == v.abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_state", {busy, bus.ps_valid, bus.cfg_ready}, 3'b001);
        @(negedge clk);
        #1 chk("abort_no_job_done", c_jd - jd0, 0);
        return;
      end
      if (j + 1 == v.n) begin
        #1 chk("job_done", job_done, 1);
      end else begin
        #1 chk("next_read", {bus.ps_valid, ren}, 2'b01);
      end
    end
    @(negedge clk);
    #1 chk("idle_after", {busy, job_done, bus.cfg_ready}, 3'b001);
    chk("n_wen_flt", c_wf - wf0, v.fs);
    chk("n_wen_if", c_wi - wi0, v.rl);
    chk("n_start", c_st - st0, 1);
    chk("n_ren", c_ren - rn0, v.n);
    chk("n_job_done", c_jd - jd0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    //         s  fs  rl err n bp stray abort
    vecs[0]  = '{1, 3,  8, 0, 6, 0, 0, 0};
    vecs[1]  = '{2, 3,  9, 0, 4, 0, 0, 0};
    vecs[2]  = '{0, 3,  8, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 0,  8, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 3,  2, 1, 0, 0, 0, 0};
    vecs[5]  = '{1, 3, 17, 1, 0, 0, 0, 0};
    vecs[6]  = '{1, 17, 16, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 3,  8, 0, 6, 1, 1, 0};
    vecs[8]  = '{1, 3,  8, 0, 6, 0, 0, 2};
    vecs[9]  = '{1, 16, 16, 0, 1, 0, 0, 0};
    vecs[10] = '{7, 1, 16, 0, 3, 0, 0, 0};

    rst = 1'b1; done = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_stride = '0; bus.cfg_filter_size = '0; bus.cfg_row_len = '0;
    bus.if_valid = 1'b0; bus.if_data = '0; bus.flt_valid = 1'b0; bus.flt_data = '0;
    bus.ps_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_ctrl", {busy, chip_en, start, wen_if, wen_flt, ren, job_done}, 7'b0);
    chk("rst_stream", {bus.ps_valid, bus.cfg_err, bus.if_ready, bus.flt_ready}, 4'b0);
    chk("rst_cfg_out", {stride_o, fs_o}, 0);
    chk("rst_data", {IFMap_in, Filter_in, bus.ps_data}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].err != 0) reject_cfg(vecs[i]);
      else                  run_job(vecs[i]);
    end
    // Fresh job after the mid-drain reset and corner cases.
    run_job(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
